// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite configuration arbiter.
package axi_lite_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_RADDR,
      S_RDATA,
      S_DONE
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int TO_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer remembers the last accepted winner.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       gnt_vld,
   output logic       gnt_idx
);

   logic last_q;

   assign gnt_vld = |req;
   // On contention the requester that did not win last time gets the grant.
   assign gnt_idx = (req == 2'b11) ? ~last_q : req[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (accept && gnt_vld) begin
         last_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/axi_lite_cfg_arbiter.sv
// Shares one AXI4-Lite master port between two register requesters with
// round-robin grant, single-beat sequencing and a handshake timeout.
module axi_lite_cfg_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_resp,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_resp,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [2:0]          M_AXI_AWPROT,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic [2:0]          M_AXI_ARPROT,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY,
   output logic                timeout_err
);

   localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

   arb_state_t            state_q, state_d;
   logic                  gnt_vld, gnt_idx, grant, abort;
   logic                  idx_q, aw_done_q, w_done_q, drain_q, timeout_err_q;
   logic [TO_CNT_W-1:0]   to_cnt_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q, rdata_q;
   logic [1:0]            resp_q;
   logic                  sel_we, aw_hs, w_hs, aw_ok, w_ok, timed_out;

   rr_arbiter2 u_arb (
      .clk     (ACLK),
      .rst     (ARESET),
      .req     ({m1_req, m0_req}),
      .accept  (grant),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   assign grant     = (state_q == S_IDLE) && gnt_vld;
   assign sel_we    = gnt_idx ? m1_we : m0_we;
   assign aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
   assign aw_ok     = aw_done_q || aw_hs;
   assign w_ok      = w_done_q || w_hs;
   assign timed_out = (to_cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      abort   = 1'b0;
      case (state_q)
         S_IDLE:  if (grant) state_d = sel_we ? S_WRITE : S_RADDR;
         S_WRITE: if (aw_ok && w_ok) state_d = S_WRESP; else if (timed_out) abort = 1'b1;
         S_WRESP: if (M_AXI_BVALID) state_d = S_DONE; else if (timed_out) abort = 1'b1;
         S_RADDR: if (M_AXI_ARREADY) state_d = S_RDATA; else if (timed_out) abort = 1'b1;
         S_RDATA: if (M_AXI_RVALID) state_d = S_DONE; else if (timed_out) abort = 1'b1;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_DONE;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q       <= S_IDLE;
         idx_q         <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
         drain_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= 1'b1;
         if (abort) timeout_err_q <= 1'b1;
         // Counter restarts on every state entry and only runs while waiting on the slave.
         if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) to_cnt_q <= '0;
         else to_cnt_q <= to_cnt_q + 1'b1;
         if (grant) begin
            idx_q     <= gnt_idx;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (grant) begin
         addr_q  <= gnt_idx ? m1_addr : m0_addr;
         wdata_q <= gnt_idx ? m1_wdata : m0_wdata;
         rdata_q <= '0;
         resp_q  <= RESP_OKAY;
      end else if (abort) begin
         rdata_q <= '0;
         resp_q  <= RESP_SLVERR;
      end else if (state_q == S_WRESP && M_AXI_BVALID) begin
         resp_q  <= M_AXI_BRESP;
      end else if (state_q == S_RDATA && M_AXI_RVALID) begin
         rdata_q <= M_AXI_RDATA;
         resp_q  <= M_AXI_RRESP;
      end
   end

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = (state_q == S_WRITE) && !aw_done_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = (state_q == S_WRITE) && !w_done_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = (state_q == S_RADDR);
   // Readies stay open in IDLE so late responses after an abort are swallowed.
   assign M_AXI_BREADY  = (state_q == S_WRESP) || (state_q == S_IDLE && drain_q);
   assign M_AXI_RREADY  = (state_q == S_RDATA) || (state_q == S_IDLE && drain_q);

   assign m0_ack   = (state_q == S_DONE) && !idx_q;
   assign m1_ack   = (state_q == S_DONE) && idx_q;
   assign m0_rdata = m0_ack ? rdata_q : '0;
   assign m1_rdata = m1_ack ? rdata_q : '0;
   assign m0_resp  = m0_ack ? resp_q : 2'b00;
   assign m1_resp  = m1_ack ? resp_q : 2'b00;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_lite_cfg_arbiter.sv
// Directed bench for axi_lite_cfg_arbiter with a small reactive AXI4-Lite slave model.
module tb_axi_lite_cfg_arbiter;
   import axi_lite_arb_pkg::*;

   localparam int TMO = 16;

   logic        tb_ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_resp, m1_resp;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY;
   logic        M_AXI_AWREADY = 0, M_AXI_WREADY = 0, M_AXI_ARREADY = 0;
   logic        M_AXI_BVALID = 0, M_AXI_RVALID = 0;
   logic [1:0]  M_AXI_BRESP = 0, M_AXI_RRESP = 0;
   logic [31:0] M_AXI_RDATA = 0;
   logic        timeout_err;

   always #5 tb_ACLK = ~tb_ACLK;

   axi_lite_cfg_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .ACLK(tb_ACLK), .ARESET(ARESET),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .timeout_err(timeout_err)
   );

   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Slave model knobs and observation counters
   int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
   bit          ar_never = 0, b_hold = 0, aw_got = 0, w_got = 0, r_pend = 0;
   bit          b_clr, r_clr, bready_in_write = 0;
   logic [1:0]  rresp_val = 2'b00;
   logic [31:0] wa, wd, ra;
   logic [31:0] mem [0:15];
   int          n_aw_hs = 0, n_w_hs = 0, n_ack = 0, ar_cycles = 0;

   always @(posedge tb_ACLK) begin
      b_clr = 0;
      r_clr = 0;
      if (!ARESET) begin
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            aw_got = 1; wa = M_AXI_AWADDR; aw_cnt = 0; n_aw_hs++;
         end else if (M_AXI_AWVALID) aw_cnt++;
         if (M_AXI_WVALID && M_AXI_WREADY) begin
            w_got = 1; wd = M_AXI_WDATA; w_cnt = 0; n_w_hs++;
         end else if (M_AXI_WVALID) w_cnt++;
         if (M_AXI_BVALID && M_AXI_BREADY) b_clr = 1;
         if (M_AXI_ARVALID) ar_cycles++;
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin r_pend = 1; ra = M_AXI_ARADDR; end
         if (M_AXI_RVALID && M_AXI_RREADY) r_clr = 1;
         if (m0_ack || m1_ack) n_ack++;
         if (M_AXI_BREADY && dut.state_q == S_WRITE) bready_in_write = 1;
      end
      #1;
      if (ARESET) begin
         aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
         M_AXI_BVALID = 0; M_AXI_RVALID = 0;
      end else begin
         if (b_clr) M_AXI_BVALID = 0;
         if (r_clr) M_AXI_RVALID = 0;
         if (aw_got && w_got && !b_hold) begin
            mem[wa[5:2]] = wd;
            M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
            aw_got = 0; w_got = 0;
         end
         if (r_pend) begin
            M_AXI_RVALID = 1; M_AXI_RDATA = mem[ra[5:2]]; M_AXI_RRESP = rresp_val;
            r_pend = 0;
         end
         M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
         M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_delay);
         M_AXI_ARREADY = M_AXI_ARVALID && !ar_never;
      end
   end

   task automatic tick();
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic do_txn(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, output logic [1:0] resp, output logic [31:0] rdata,
                         output int lat, output logic [2:0] v1);
      bit got;
      got = 0; lat = 0; v1 = '0; resp = '0; rdata = '0;
      if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
      else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (i == 1) v1 = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID};
         if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
            got = 1; lat = i;
            resp  = (m == 0) ? m0_resp : m1_resp;
            rdata = (m == 0) ? m0_rdata : m1_rdata;
            break;
         end
      end
      check("ack_seen", 32'(got), 32'd1);
      if (!hold) begin
         if (m == 0) m0_req = 0; else m1_req = 0;
      end
   endtask

   task automatic do_reset();
      ARESET = 1; m0_req = 0; m1_req = 0;
      tick();
      tick();
   endtask

   logic [1:0]  rsp;
   logic [31:0] rd;
   int          lat, a0, w0, k0, c0;
   logic [2:0]  v1;
   int          order[$];
   bit          reached;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;

      // Reset values
      do_reset();
      check("rst_awvalid", 32'(M_AXI_AWVALID), 0);
      check("rst_wvalid",  32'(M_AXI_WVALID), 0);
      check("rst_arvalid", 32'(M_AXI_ARVALID), 0);
      check("rst_bready",  32'(M_AXI_BREADY), 0);
      check("rst_rready",  32'(M_AXI_RREADY), 0);
      check("rst_acks",    32'({m0_ack, m1_ack}), 0);
      check("rst_rdata",   m0_rdata | m1_rdata, 0);
      check("rst_resp",    32'({m0_resp, m1_resp}), 0);
      check("rst_terr",    32'(timeout_err), 0);
      ARESET = 0;
      tick();
      check("idle_drain",  32'({M_AXI_BREADY, M_AXI_RREADY}), 32'b11);

      // 1: single write then read-back, zero-wait slave
      do_txn(0, 1, 32'h0, 32'h0101FFFF, 0, rsp, rd, lat, v1);
      check("t1_w_valids", 32'(v1), 32'b110);
      check("t1_w_lat", lat, 3);
      check("t1_w_resp", 32'(rsp), 0);
      tick();
      do_txn(0, 0, 32'h0, 32'h0, 0, rsp, rd, lat, v1);
      check("t1_r_valids", 32'(v1), 32'b001);
      check("t1_r_lat", lat, 3);
      check("t1_r_data", rd, 32'h0101FFFF);
      check("t1_r_resp", 32'(rsp), 0);

      // 2: simultaneous requests held continuously alternate m0,m1,m0,m1
      do_reset();
      ARESET = 0;
      tick();
      fork
         begin
            logic [1:0] r; logic [31:0] d; int l; logic [2:0] v;
            do_txn(0, 1, 32'h4, 32'habcd0001, 1, r, d, l, v); order.push_back(0);
            do_txn(0, 1, 32'h4, 32'habcd0001, 0, r, d, l, v); order.push_back(0);
         end
         begin
            logic [1:0] r; logic [31:0] d; int l; logic [2:0] v;
            do_txn(1, 1, 32'h8, 32'hdead0011, 1, r, d, l, v); order.push_back(1);
            do_txn(1, 1, 32'h8, 32'hdead0011, 0, r, d, l, v); order.push_back(1);
         end
      join
      check("t2_count", order.size(), 4);
      for (int i = 0; i < 4 && i < order.size(); i++) check("t2_order", order[i], i % 2);
      check("t2_mem4", mem[1], 32'habcd0001);
      check("t2_mem8", mem[2], 32'hdead0011);
      tick();

      // 3: W delayed after AW, then AW delayed after W
      for (int pass = 0; pass < 2; pass++) begin
         aw_delay = (pass == 0) ? 0 : 3;
         w_delay  = (pass == 0) ? 3 : 0;
         a0 = n_aw_hs; w0 = n_w_hs; k0 = n_ack; bready_in_write = 0;
         do_txn(0, 1, 32'h10, 32'h11112222 + pass, 0, rsp, rd, lat, v1);
         tick();
         check("t3_lat", lat, 6);
         check("t3_resp", 32'(rsp), 0);
         check("t3_aw_hs", n_aw_hs - a0, 1);
         check("t3_w_hs", n_w_hs - w0, 1);
         check("t3_acks", n_ack - k0, 1);
         check("t3_bready_early", 32'(bready_in_write), 0);
         check("t3_mem", mem[4], 32'h11112222 + pass);
      end
      aw_delay = 0; w_delay = 0;

      // 6: slave DECERR on a read passes through untouched
      rresp_val = 2'b11;
      do_txn(1, 0, 32'h4, 32'h0, 0, rsp, rd, lat, v1);
      check("t6_resp", 32'(rsp), 32'b11);
      check("t6_data", rd, 32'habcd0001);
      check("t6_terr", 32'(timeout_err), 0);
      rresp_val = 2'b00;
      tick();

      // 4: ARREADY never arrives -> abort with SLVERR, sticky error
      ar_never = 1;
      c0 = ar_cycles;
      do_txn(0, 0, 32'h0, 32'h0, 0, rsp, rd, lat, v1);
      check("t4_lat", lat, TMO + 1);
      check("t4_ar_cycles", ar_cycles - c0, TMO);
      check("t4_resp", 32'(rsp), 32'b10);
      check("t4_rdata", rd, 0);
      check("t4_terr", 32'(timeout_err), 1);
      check("t4_valids_drop", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 0);
      ar_never = 0;
      tick();
      do_txn(1, 1, 32'hC, 32'hbeef0011, 0, rsp, rd, lat, v1);
      tick();
      do_txn(1, 0, 32'hC, 32'h0, 0, rsp, rd, lat, v1);
      check("t4_after_data", rd, 32'hbeef0011);
      check("t4_after_resp", 32'(rsp), 0);
      check("t4_terr_sticky", 32'(timeout_err), 1);
      tick();

      // 5: reset while waiting for the write response
      b_hold = 1;
      k0 = n_ack;
      m0_req = 1; m0_we = 1; m0_addr = 32'h14; m0_wdata = 32'h55aa55aa;
      reached = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dut.state_q == S_WRESP) begin reached = 1; break; end
      end
      check("t5_reach_wresp", 32'(reached), 1);
      tick();
      ARESET = 1; m0_req = 0;
      tick();
      check("t5_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 0);
      check("t5_state", 32'(dut.state_q), 32'(S_IDLE));
      check("t5_ack", 32'({m0_ack, m1_ack}), 0);
      check("t5_terr", 32'(timeout_err), 0);
      ARESET = 0; b_hold = 0;
      tick();
      tick();
      check("t5_no_ack", n_ack - k0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
